// File: rtl/byte_fifo.sv
// Eight-entry first-word-fall-through byte queue behind the storage register.
// Occupancy and all flags decode from the registered count only.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // Handshake: a byte moves only on a rising edge where valid and ready are
    // both high; ready never depends on the partner's valid in the same cycle.
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Contents stay in place; only the bookkeeping is discarded.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign count     = cnt;
    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_byte_fifo.sv
// Bench for byte_fifo: directed phases drive the ports, a negedge monitor
// tracks an expected queue and checks flags and head data every cycle.
module tb_byte_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    int               checks;
    int               failures;

    byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // scoreboard / monitor: checks state seen after the last edge, then
    // applies the transfers the coming edge will perform
    initial begin
        logic m_push;
        logic m_pop;
        int   n;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
            end else begin
                n = exp_q.size();
                check("mon_count", 32'(count), 32'(n));
                check("mon_full", 32'(full), 32'(n == DEPTH));
                check("mon_empty", 32'(empty), 32'(n == 0));
                check("mon_in_ready", 32'(in_ready), 32'(n != DEPTH));
                check("mon_out_valid", 32'(out_valid), 32'(n != 0));
                if (n != 0) check("mon_out_data", 32'(out_data), 32'(exp_q[0]));
                else        check("mon_out_data_idle", 32'(out_data), 32'(0));
                m_push = in_valid && (n != DEPTH);
                m_pop  = out_ready && (n != 0);
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (m_pop) begin
                        got_q.push_back(out_data);
                        void'(exp_q.pop_front());
                    end
                    if (m_push) exp_q.push_back(in_data);
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] sent[$];
        logic [WIDTH-1:0] b;
        checks   = 0;
        failures = 0;

        // 1: reset
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b1;
        check("rst_count", 32'(count), 32'(0));
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_full", 32'(full), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));

        // 2: fill to full, then hold a 9th byte
        for (int i = 0; i < 8; i++) begin
            b = 8'((i + 1) * 8'h11);
            drive(1'b1, b, 1'b0, 1'b0);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
        end
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        step();
        step();
        check("full_hold_count", 32'(count), 32'(8));
        check("full_flag", 32'(full), 32'(1));
        check("full_in_ready", 32'(in_ready), 32'(0));
        check("full_head", 32'(out_data), 32'(8'h11));

        // 3: drain; 0x99 enters on the edge after full drops
        got_q.delete();
        drive(1'b1, 8'h99, 1'b1, 1'b0);
        step();
        check("drain_ready_rise", 32'(in_ready), 32'(1));
        step();
        check("drain_99_taken", 32'(count), 32'(7));
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step();
        check("drain_count", 32'(count), 32'(0));
        check("drain_empty", 32'(empty), 32'(1));
        step();  // out_ready high while empty must be ignored
        check("empty_ignore", 32'(count), 32'(0));
        check("drain_len", 32'(got_q.size()), 32'(9));
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            b = (i == 8) ? 8'h99 : 8'((i + 1) * 8'h11);
            check("drain_order", 32'(got_q[i]), 32'(b));
        end

        // 4: concurrent push/pop across the pointer wrap
        got_q.delete();
        sent.delete();
        for (int i = 0; i < 3; i++) begin
            b = 8'hA0 + 8'(i);
            sent.push_back(b);
            drive(1'b1, b, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            drive(1'b1, b, 1'b1, 1'b0);
            step();
            check("conc_count", 32'(count), 32'(3));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("conc_len", 32'(got_q.size()), 32'(15));
        for (int i = 0; i < 15 && i < got_q.size(); i++) begin
            check("conc_order", 32'(got_q[i]), 32'(sent[i]));
        end

        // 5: flush beats a coincident push and pop
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
            step();
        end
        check("pre_flush_count", 32'(count), 32'(5));
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("flush_count", 32'(count), 32'(0));
        check("flush_empty", 32'(empty), 32'(1));
        check("flush_out_data", 32'(out_data), 32'(0));
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_flush_data", 32'(out_data), 32'(8'hA5));
        check("post_flush_count", 32'(count), 32'(1));
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // 6: asynchronous reset with six entries queued
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'(6));
        #2;
        reset = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'(0));
        check("midrst_empty", 32'(empty), 32'(1));
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_data", 32'(out_data), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        step();
        reset = 1'b1;
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("after_rst_data", 32'(out_data), 32'(8'h3C));
        check("after_rst_count", 32'(count), 32'(1));
        step();

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
